ifetch_unit: RTL

//  Instruction fetch front end feeding the mips core's decode/control path.

---
 rtl/ifetch_unit_if.sv | 28 ++
 rtl/ifetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit_if.sv
// Fetch unit bundle: instruction memory request/response, core redirect and instruction stream.
// master = fetch unit side, slave = memory/core environment side.
interface ifetch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [DATA_W-1:0] imem_rsp_data;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [DATA_W-1:0] inst_data;
   logic [ADDR_W-1:0] inst_pc;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC sequencing, credit-limited imem requests, prefetch FIFO and
// redirect flush with stale-response discard. Define IFETCH_STATS_EN for stat_fetched/stat_dropped.
module ifetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   ifetch_unit_if.master bus
`ifdef IFETCH_STATS_EN
   ,
   output logic [31:0]   stat_fetched,
   output logic [31:0]   stat_dropped
`endif
);
   localparam int                PTR_W   = $clog2(DEPTH);
   localparam int                CNT_W   = PTR_W + 1;
   localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
   logic [ADDR_W-1:0] rsp_pc_reg, rsp_pc_next;
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
   logic [CNT_W-1:0]  discard_reg, discard_next;

   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem   [DEPTH];

   logic              redirect;
   logic [ADDR_W-1:0] redirect_target;
   logic [CNT_W:0]    credit_used;
   logic              req_valid;
   logic              req_fire;
   logic              rsp_in;
   logic              push;
   logic              pop;
   logic              head_valid;

   assign redirect        = bus.redirect_valid;
   assign redirect_target = bus.redirect_pc & ~ADDR_W'(3);
   assign credit_used     = {1'b0, count_reg} + {1'b0, outstanding_reg};
   assign head_valid      = (count_reg != '0);

   // A response with nothing outstanding is a protocol error; ignoring it keeps the counters sane.
   assign rsp_in   = bus.imem_rsp_valid && (outstanding_reg != '0);
   assign req_fire = req_valid && bus.imem_req_ready;
   assign push     = (state_reg == ST_RUN) && rsp_in && !redirect;
   assign pop      = head_valid && bus.inst_ready && !redirect;

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_BOOT;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM: next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_BOOT: begin
            state_next = ST_RUN;
         end
         ST_RUN: begin
            if (redirect && outstanding_next != '0) begin
               state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (redirect) begin
               state_next = (outstanding_next != '0) ? ST_FLUSH : ST_RUN;
            end else if (discard_next == '0) begin
               state_next = ST_RUN;
            end
         end
         default: begin
            state_next = ST_BOOT;
         end
      endcase
   end

   // FSM: outputs
   always_comb begin
      req_valid = 1'b0;
      if (state_reg == ST_RUN && !redirect && credit_used < DEPTH_C) begin
         req_valid = 1'b1;
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_reg;
   assign bus.inst_valid     = head_valid;
   assign bus.inst_data      = head_valid ? data_mem[rd_ptr_reg] : '0;
   assign bus.inst_pc        = head_valid ? pc_mem[rd_ptr_reg]   : '0;

   // Datapath next-state; a redirect overrides every other update this cycle.
   always_comb begin
      fetch_pc_next    = fetch_pc_reg;
      rsp_pc_next      = rsp_pc_reg;
      wr_ptr_next      = wr_ptr_reg;
      rd_ptr_next      = rd_ptr_reg;
      count_next       = count_reg;
      discard_next     = discard_reg;
      outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(rsp_in);
      if (redirect) begin
         fetch_pc_next = redirect_target;
         rsp_pc_next   = redirect_target;
         wr_ptr_next   = '0;
         rd_ptr_next   = '0;
         count_next    = '0;
         // Everything still in flight after this cycle belongs to the old path.
         discard_next  = outstanding_next;
      end else begin
         if (req_fire) begin
            fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
         end
         if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            rsp_pc_next = rsp_pc_reg + ADDR_W'(4);
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
         end
         count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
         if (state_reg == ST_FLUSH && rsp_in && discard_reg != '0) begin
            discard_next = discard_reg - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_reg    <= RESET_PC;
         rsp_pc_reg      <= RESET_PC;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
         outstanding_reg <= '0;
         discard_reg     <= '0;
      end else begin
         fetch_pc_reg    <= fetch_pc_next;
         rsp_pc_reg      <= rsp_pc_next;
         wr_ptr_reg      <= wr_ptr_next;
         rd_ptr_reg      <= rd_ptr_next;
         count_reg       <= count_next;
         outstanding_reg <= outstanding_next;
         discard_reg     <= discard_next;
      end
   end

   // FIFO storage needs no reset: count_reg alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_reg] <= bus.imem_rsp_data;
         pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
      end
   end

`ifdef IFETCH_STATS_EN
   logic [31:0] stat_fetched_reg;
   logic [31:0] stat_dropped_reg;
   logic [31:0] drop_inc;

   // Dropped = discarded responses plus FIFO entries thrown away by a redirect.
   always_comb begin
      drop_inc = 32'd0;
      if (redirect) begin
         drop_inc = 32'(count_reg) + 32'(rsp_in);
      end else if (rsp_in && !push) begin
         drop_inc = 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_fetched_reg <= 32'd0;
         stat_dropped_reg <= 32'd0;
      end else begin
         stat_fetched_reg <= stat_fetched_reg + 32'(push);
         stat_dropped_reg <= stat_dropped_reg + drop_inc;
      end
   end

   assign stat_fetched = stat_fetched_reg;
   assign stat_dropped = stat_dropped_reg;
`endif
endmodule
